// File: rtl/decode_pkg.sv
// Shared types and field helpers for the fost decode stage.
// Helpers work on a MAX_W-bit container so any parameterisation can reuse them.
package decode_pkg;
  localparam int MAX_W = 64;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,  OP_ADD  = 4'd1,  OP_SUB  = 4'd2,  OP_AND  = 4'd3,
    OP_OR   = 4'd4,  OP_ADDI = 4'd5,  OP_SUBI = 4'd6,  OP_INCR = 4'd7,
    OP_LDI  = 4'd8,  OP_LD   = 4'd9,  OP_ST   = 4'd10, OP_RSV  = 4'd11,
    OP_BEQ  = 4'd12, OP_BGT  = 4'd13, OP_JUMP = 4'd14, OP_HALT = 4'd15
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2,
    ALU_OR  = 3'd3, ALU_GT  = 3'd4, ALU_EQ  = 3'd5
  } alu_op_t;

  typedef struct packed {
    alu_op_t alu_op;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    branch;
    logic    jump;
    logic    halt;
  } ctrl_t;

  function automatic logic [MAX_W-1:0] zext(input logic [MAX_W-1:0] v, input int w);
    logic [MAX_W-1:0] r;
    for (int i = 0; i < MAX_W; i++) r[i] = (i < w) ? v[i] : 1'b0;
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] sext(input logic [MAX_W-1:0] v, input int w);
    logic [MAX_W-1:0] r;
    for (int i = 0; i < MAX_W; i++) r[i] = (i < w) ? v[i] : v[w-1];
    return r;
  endfunction

  function automatic opcode_t f_opcode(input logic [MAX_W-1:0] inst, input int ra_w);
    return opcode_t'(inst[3*ra_w +: 4]);
  endfunction

  // slot 2 = rd, 1 = rs, 0 = rt
  function automatic logic [MAX_W-1:0] f_reg(input logic [MAX_W-1:0] inst, input int ra_w,
                                             input int slot);
    return zext(inst >> (ra_w * slot), ra_w);
  endfunction
endpackage

// File: rtl/decode_stage_p_regfile.sv
// Architectural register file: two async read ports with write-through, one write port.
module regfile_2r1w #(
  parameter int XLEN = 16,
  parameter int RA_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [RA_W-1:0] waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [RA_W-1:0] raddr_a,
  input  logic [RA_W-1:0] raddr_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b
);
  logic [(2**RA_W)-1:0][XLEN-1:0] regs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    regs <= '0;
    else if (we) regs[waddr] <= wdata;
  end

  // a same-cycle write is visible to readers before it lands
  assign rdata_a = (we && waddr == raddr_a) ? wdata : regs[raddr_a];
  assign rdata_b = (we && waddr == raddr_b) ? wdata : regs[raddr_b];
endmodule

// File: rtl/decode_stage_p.sv
// Decode stage: field decode, operand forwarding, load-use stall, output register and halt.
module decode_stage_p
  import decode_pkg::*;
#(
  parameter  int XLEN   = 16,
  parameter  int PC_W   = 16,
  parameter  int RA_W   = 4,
  localparam int INST_W = 4 + 3*RA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output ctrl_t             out_ctrl,
  output logic [XLEN-1:0]   out_val1,
  output logic [XLEN-1:0]   out_val2,
  output logic [XLEN-1:0]   out_val3,
  output logic [PC_W-1:0]   out_pc,
  input  logic              ex_wr_en,
  input  logic [RA_W-1:0]   ex_wr_addr,
  input  logic [XLEN-1:0]   ex_wr_data,
  input  logic              ex_is_load,
  input  logic              wb_wr_en,
  input  logic [RA_W-1:0]   wb_wr_addr,
  input  logic [XLEN-1:0]   wb_wr_data,
  output logic              halted
);
  logic [MAX_W-1:0]    inst_w;
  opcode_t             op;
  logic [RA_W-1:0]     rd, rs, rt;
  logic [2*RA_W-1:0]   imm;
  logic [XLEN-1:0]     rf_rd, rf_rs, r_rd, r_rs;
  logic [XLEN-1:0]     imm_s, br_tgt, jmp_tgt;
  ctrl_t               d_ctrl;
  logic [XLEN-1:0]     d_v1, d_v2, d_v3;
  logic                uses_rd, uses_rs, stall, accept;

  assign inst_w = MAX_W'(in_inst);
  assign op     = f_opcode(inst_w, RA_W);
  assign rd     = RA_W'(f_reg(inst_w, RA_W, 2));
  assign rs     = RA_W'(f_reg(inst_w, RA_W, 1));
  assign rt     = RA_W'(f_reg(inst_w, RA_W, 0));
  assign imm    = {rs, rt};

  regfile_2r1w #(.XLEN(XLEN), .RA_W(RA_W)) u_rf (
    .clk(clk), .rst(rst), .we(wb_wr_en), .waddr(wb_wr_addr), .wdata(wb_wr_data),
    .raddr_a(rd), .raddr_b(rs), .rdata_a(rf_rd), .rdata_b(rf_rs)
  );

  // execute result outranks write-back (already folded into the regfile read)
  assign r_rd = (ex_wr_en && ex_wr_addr == rd) ? ex_wr_data : rf_rd;
  assign r_rs = (ex_wr_en && ex_wr_addr == rs) ? ex_wr_data : rf_rs;

  assign imm_s   = XLEN'(sext(MAX_W'(imm), 2*RA_W));
  assign br_tgt  = XLEN'(PC_W'(in_pc + PC_W'(sext(MAX_W'(rt), RA_W))));
  assign jmp_tgt = XLEN'(PC_W'(r_rs));

  always_comb begin
    d_ctrl  = '0;
    d_v1    = '0;
    d_v2    = '0;
    d_v3    = '0;
    uses_rd = 1'b0;
    uses_rs = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        d_ctrl.alu_op    = (op == OP_SUB) ? ALU_SUB : (op == OP_AND) ? ALU_AND :
                           (op == OP_OR)  ? ALU_OR  : ALU_ADD;
        d_ctrl.reg_write = 1'b1;
        d_v1 = r_rd; d_v2 = r_rs; d_v3 = XLEN'(rd);
        uses_rd = 1'b1; uses_rs = 1'b1;
      end
      OP_ADDI, OP_SUBI, OP_INCR: begin
        d_ctrl.alu_op    = (op == OP_SUBI) ? ALU_SUB : ALU_ADD;
        d_ctrl.reg_write = 1'b1;
        d_v1 = r_rd; d_v2 = (op == OP_INCR) ? XLEN'(1) : imm_s; d_v3 = XLEN'(rd);
        uses_rd = 1'b1;
      end
      OP_LDI: begin
        d_ctrl.mem_read = 1'b1; d_ctrl.reg_write = 1'b1;
        d_v1 = XLEN'(imm); d_v3 = XLEN'(rd);
      end
      OP_LD: begin
        d_ctrl.mem_read = 1'b1; d_ctrl.reg_write = 1'b1;
        d_v1 = r_rs; d_v2 = XLEN'(rt); d_v3 = XLEN'(rd);
        uses_rs = 1'b1;
      end
      OP_ST: begin
        d_ctrl.mem_write = 1'b1;
        d_v1 = r_rs; d_v2 = XLEN'(rt); d_v3 = r_rd;
        uses_rd = 1'b1; uses_rs = 1'b1;
      end
      OP_BEQ, OP_BGT: begin
        d_ctrl.alu_op = (op == OP_BEQ) ? ALU_EQ : ALU_GT;
        d_ctrl.branch = 1'b1;
        d_v1 = r_rd; d_v2 = r_rs; d_v3 = br_tgt;
        uses_rd = 1'b1; uses_rs = 1'b1;
      end
      OP_JUMP: begin
        d_ctrl.jump = 1'b1;
        d_v3 = jmp_tgt;
        uses_rs = 1'b1;
      end
      OP_HALT: d_ctrl.halt = 1'b1;
      default: ;
    endcase
  end

  // only registers the opcode really reads can cause a load-use hazard
  assign stall    = ex_is_load && ex_wr_en &&
                    ((uses_rd && ex_wr_addr == rd) || (uses_rs && ex_wr_addr == rs));
  assign in_ready = !halted && !stall && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_val1  <= '0;
      out_val2  <= '0;
      out_val3  <= '0;
      out_pc    <= '0;
      halted    <= 1'b0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_ctrl  <= d_ctrl;
        out_val1  <= d_v1;
        out_val2  <= d_v2;
        out_val3  <= d_v3;
        out_pc    <= in_pc;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready && out_ctrl.halt) halted <= 1'b1;
    end
  end
endmodule

// File: tb/tb_decode_stage_p.sv
// Randomised + directed bench for decode_stage_p with a queue scoreboard and behavioural model.
module tb_decode_stage_p;
  import decode_pkg::*;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready, halted;
  logic [15:0] in_inst, in_pc, out_val1, out_val2, out_val3, out_pc;
  ctrl_t       out_ctrl;
  logic        ex_wr_en, ex_is_load, wb_wr_en;
  logic [3:0]  ex_wr_addr, wb_wr_addr;
  logic [15:0] ex_wr_data, wb_wr_data;

  decode_stage_p #(.XLEN(16), .PC_W(16), .RA_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_val1(out_val1), .out_val2(out_val2), .out_val3(out_val3),
    .out_pc(out_pc), .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data),
    .ex_is_load(ex_is_load), .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr),
    .wb_wr_data(wb_wr_data), .halted(halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    ctrl_t       ctrl;
    logic [15:0] v1, v2, v3, pc;
    bit          c1, c2, c3;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m_regs [16];
  bit          m_halted;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rval(input int x);
    if (ex_wr_en && int'(ex_wr_addr) == x) return ex_wr_data;
    if (wb_wr_en && int'(wb_wr_addr) == x) return wb_wr_data;
    return m_regs[x];
  endfunction

  function automatic exp_t predict();
    exp_t e;
    int op, rd, rs, rt, imm;
    op = int'(in_inst[15:12]); rd = int'(in_inst[11:8]);
    rs = int'(in_inst[7:4]);   rt = int'(in_inst[3:0]); imm = int'(in_inst[7:0]);
    e.ctrl = '0; e.v1 = '0; e.v2 = '0; e.v3 = '0; e.pc = in_pc;
    e.c1 = 1; e.c2 = 1; e.c3 = 1;
    case (op)
      1, 2, 3, 4: begin
        e.ctrl.alu_op = (op == 2) ? ALU_SUB : (op == 3) ? ALU_AND : (op == 4) ? ALU_OR : ALU_ADD;
        e.ctrl.reg_write = 1;
        e.v1 = rval(rd); e.v2 = rval(rs); e.v3 = 16'(rd);
      end
      5, 6, 7: begin
        e.ctrl.alu_op = (op == 6) ? ALU_SUB : ALU_ADD;
        e.ctrl.reg_write = 1;
        e.v1 = rval(rd);
        e.v2 = (op == 7) ? 16'd1 : (imm >= 128) ? 16'(imm - 256) : 16'(imm);
        e.v3 = 16'(rd);
      end
      8: begin
        e.ctrl.mem_read = 1; e.ctrl.reg_write = 1;
        e.v1 = 16'(imm); e.v2 = 16'd0; e.v3 = 16'(rd);
      end
      9: begin
        e.ctrl.mem_read = 1; e.ctrl.reg_write = 1;
        e.v1 = rval(rs); e.v2 = 16'(rt); e.v3 = 16'(rd);
      end
      10: begin
        e.ctrl.mem_write = 1;
        e.v1 = rval(rs); e.v2 = 16'(rt); e.v3 = rval(rd);
      end
      12, 13: begin
        e.ctrl.alu_op = (op == 12) ? ALU_EQ : ALU_GT;
        e.ctrl.branch = 1;
        e.v1 = rval(rd); e.v2 = rval(rs);
        e.v3 = 16'(int'(in_pc) + ((rt >= 8) ? rt - 16 : rt));
      end
      14: begin
        e.ctrl.jump = 1; e.v3 = rval(rs); e.c1 = 0; e.c2 = 0;
      end
      15: begin
        e.ctrl.halt = 1; e.c1 = 0; e.c2 = 0; e.c3 = 0;
      end
      default: begin
        e.c1 = 0; e.c2 = 0; e.c3 = 0;
      end
    endcase
    return e;
  endfunction

  // reference model: runs just before each rising edge with inputs settled
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      m_halted = 0;
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
    end else begin
      int  op, rd, rs;
      bit  srd, srs, stl, rdy;
      op  = int'(in_inst[15:12]); rd = int'(in_inst[11:8]); rs = int'(in_inst[7:4]);
      srd = op inside {1, 2, 3, 4, 5, 6, 7, 10, 12, 13};
      srs = op inside {1, 2, 3, 4, 9, 10, 12, 13, 14};
      stl = ex_is_load && ex_wr_en &&
            ((srd && int'(ex_wr_addr) == rd) || (srs && int'(ex_wr_addr) == rs));
      rdy = !m_halted && !stl && (q.size() == 0 || out_ready);
      chk("in_ready", 32'(in_ready), 32'(rdy));
      chk("halted", 32'(halted), 32'(m_halted));
      if (q.size() != 0 && out_ready) begin
        if (q[0].ctrl.halt) m_halted = 1;
        void'(q.pop_front());
      end else if (q.size() != 0 && flush) begin
        void'(q.pop_front());
      end
      if (in_valid && rdy && !flush) q.push_back(predict());
      if (wb_wr_en) m_regs[wb_wr_addr] = wb_wr_data;
    end
  end

  // monitor: compares the presented bundle against the scoreboard head every cycle
  always @(posedge clk) begin
    #2;
    if (rst) begin
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (out_valid && q.size() != 0) begin
        chk("out_ctrl", 32'(out_ctrl), 32'(q[0].ctrl));
        chk("out_pc", 32'(out_pc), 32'(q[0].pc));
        if (q[0].c1) chk("out_val1", 32'(out_val1), 32'(q[0].v1));
        if (q[0].c2) chk("out_val2", 32'(out_val2), 32'(q[0].v2));
        if (q[0].c3) chk("out_val3", 32'(out_val3), 32'(q[0].v3));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; flush = 0; out_ready = 1; in_inst = '0; in_pc = '0;
    ex_wr_en = 0; ex_wr_addr = '0; ex_wr_data = '0; ex_is_load = 0;
    wb_wr_en = 0; wb_wr_addr = '0; wb_wr_data = '0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_ctrl"},  32'(out_ctrl),  32'd0);
    chk({tag, "_val1"},  32'(out_val1),  32'd0);
    chk({tag, "_val2"},  32'(out_val2),  32'd0);
    chk({tag, "_val3"},  32'(out_val3),  32'd0);
    chk({tag, "_pc"},    32'(out_pc),    32'd0);
    chk({tag, "_halted"}, 32'(halted),   32'd0);
  endtask

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_inst    = {4'($urandom_range(0, 14)), 12'($urandom)};
      in_pc      = 16'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 19) == 0);
      ex_wr_en   = ($urandom_range(0, 1) == 0);
      ex_wr_addr = 4'($urandom);
      ex_wr_data = 16'($urandom);
      ex_is_load = ($urandom_range(0, 3) == 0);
      wb_wr_en   = ($urandom_range(0, 1) == 0);
      wb_wr_addr = 4'($urandom);
      wb_wr_data = 16'($urandom);
      step();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    step(); step();
    check_reset_values("reset");
    rst = 1;
    step();

    // ADDI r1,#-3
    in_valid = 1; in_inst = {4'd5, 4'd1, 8'hFD}; in_pc = 16'h0040;
    step();
    in_valid = 0;
    chk("addi_val2", 32'(out_val2), 32'h0000FFFD);
    chk("addi_val3", 32'(out_val3), 32'd1);
    chk("addi_regw", 32'(out_ctrl.reg_write), 32'd1);

    // ADD r2,r3 with ex and wb both targeting r3
    in_valid = 1; in_inst = {4'd1, 4'd2, 4'd3, 4'd0};
    ex_wr_en = 1; ex_wr_addr = 4'd3; ex_wr_data = 16'd7;
    wb_wr_en = 1; wb_wr_addr = 4'd3; wb_wr_data = 16'd9;
    step();
    idle_inputs();
    chk("fwd_ex_over_wb", 32'(out_val2), 32'd7);

    // load-use stall on SUB r4,r5
    in_valid = 1; in_inst = {4'd2, 4'd4, 4'd5, 4'd0};
    ex_is_load = 1; ex_wr_en = 1; ex_wr_addr = 4'd4; ex_wr_data = 16'h1234;
    #1 chk("stall_ready", 32'(in_ready), 32'd0);
    step();
    ex_is_load = 0; ex_wr_en = 0;
    #1 chk("unstall_ready", 32'(in_ready), 32'd1);
    step();
    chk("sub_alu", 32'(out_ctrl.alu_op), 32'(ALU_SUB));

    // LDI r4 reads nothing, so no stall
    in_inst = {4'd8, 4'd4, 8'h2A};
    ex_is_load = 1; ex_wr_en = 1; ex_wr_addr = 4'd4;
    #1 chk("ldi_nostall", 32'(in_ready), 32'd1);
    step();
    idle_inputs();
    chk("ldi_val1", 32'(out_val1), 32'h2A);

    // BEQ at pc 0x10, rt=-2, held under back-pressure
    in_valid = 1; in_inst = {4'd12, 4'd1, 4'd2, 4'hE}; in_pc = 16'h0010;
    step();
    out_ready = 0; in_inst = {4'd1, 4'd1, 4'd1, 4'd0}; in_pc = 16'h0011;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_ready", 32'(in_ready), 32'd0);
      chk("hold_val3", 32'(out_val3), 32'h0E);
      step();
    end
    idle_inputs();
    step();

    // flush with a valid bundle; earlier wb of r6 must survive
    wb_wr_en = 1; wb_wr_addr = 4'd6; wb_wr_data = 16'd5;
    step();
    wb_wr_en = 0;
    in_valid = 1; in_inst = {4'd1, 4'd1, 4'd2, 4'd0}; out_ready = 0;
    step();
    flush = 1; out_ready = 1; in_inst = {4'd3, 4'd2, 4'd2, 4'd0};
    step();
    flush = 0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    in_inst = {4'd1, 4'd7, 4'd6, 4'd0};
    step();
    idle_inputs();
    chk("flush_keep_r6", 32'(out_val2), 32'd5);
    step();

    random_cycles(400);
    step();

    // HALT: accepted, then consumed downstream
    in_valid = 1; in_inst = {4'd15, 12'h000};
    step();
    in_inst = {4'd1, 4'd2, 4'd3, 4'd0};
    step();
    chk("halt_set", 32'(halted), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("halt_ready", 32'(in_ready), 32'd0);
      step();
    end

    // asynchronous reset in the middle of a cycle
    #2 rst = 0;
    #1 check_reset_values("async_rst");
    step(); step();
    idle_inputs();
    rst = 1;
    step();
    random_cycles(60);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
